// File: rtl/car_detector_pkg.sv
`default_nettype none
// ============================================================================
// Package : car_detector_pkg
// Purpose : Shared definitions for the car_detector slice and anything that
//           talks to the Stoplight Prospect light: light codes, detector FSM
//           state encodings and the "served" decode helper.
// Revision: 1.0 - initial release
// ============================================================================
package car_detector_pkg;

  // Prospect light codes as driven by Stoplight.light_pros (one-hot).
  localparam logic [2:0] LIGHT_GRN = 3'b100;
  localparam logic [2:0] LIGHT_YLW = 3'b010;
  localparam logic [2:0] LIGHT_RED = 3'b001;

  // Detector FSM encodings.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAITING = 2'd1,
    ST_SERVED  = 2'd2
  } det_state_e;

  // A request counts as served only on an exact green code; illegal
  // multi-hot codes are treated as not served.
  function automatic logic is_served(input logic [2:0] light);
    return (light == LIGHT_GRN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/car_detector_if.sv
`default_nettype none
// ============================================================================
// Interface: car_detector_if
// Purpose  : Groups the sensor/controller-side signals of car_detector.
// Signals  : sensor_raw   - raw loop-sensor level (async to clk)
//            light_pros   - Prospect light code from Stoplight
//            car_present  - registered request to Stoplight
//            wait_count   - cycles the current request has waited (saturating)
//            sensor_fault - sticky stuck-sensor flag
// Modports : master - environment side (drives sensor/light)
//            slave  - detector side
// Revision : 1.0 - initial release
// ============================================================================
interface car_detector_if #(
  parameter int WAIT_W = 8
);
  logic              sensor_raw;
  logic [2:0]        light_pros;
  logic              car_present;
  logic [WAIT_W-1:0] wait_count;
  logic              sensor_fault;

  modport master (
    output sensor_raw,
    output light_pros,
    input  car_present,
    input  wait_count,
    input  sensor_fault
  );

  modport slave (
    input  sensor_raw,
    input  light_pros,
    output car_present,
    output wait_count,
    output sensor_fault
  );
endinterface
`default_nettype wire

// File: rtl/car_detector_sync_debounce.sv
`default_nettype none
// ============================================================================
// Module  : car_detector_sync_debounce
// Purpose : Synchronizes the asynchronous loop-sensor level into clk and
//           debounces it. deb_o only flips after the synchronized level has
//           disagreed with it for DEBOUNCE consecutive cycles.
// Ports   : clk      - system clock
//           rst_n    - asynchronous active-low reset
//           sensor_i - raw sensor level, asynchronous to clk
//           deb_o    - debounced sensor level
// Params  : SYNC_STAGES (>=2), DEBOUNCE (>=1)
// Revision: 1.0 - initial release
// ============================================================================
module car_detector_sync_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sensor_i,
  output logic deb_o
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic                   deb_q, deb_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sensor_i};
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // The counter tracks how long sync_s has disagreed with deb. The edge on
  // which it would reach DEBOUNCE is the edge that flips deb, so the counter
  // is left at zero there instead of storing DEBOUNCE.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_s != deb_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign deb_o = deb_q;

endmodule
`default_nettype wire

// File: rtl/car_detector.sv
`default_nettype none
// ============================================================================
// Module  : car_detector
// Purpose : Front end for Stoplight.car_present. Turns the bouncy Prospect
//           loop sensor into a latched request that is held until the
//           Prospect light goes green, then follows the sensor so a stream of
//           cars keeps the request asserted.
// Ports   : clk   - system clock (one tick = one controller time step)
//           rst_n - asynchronous active-low reset
//           det   - car_detector_if.slave (sensor_raw, light_pros,
//                   car_present, wait_count, sensor_fault)
// Params  : SYNC_STAGES, DEBOUNCE, WAIT_W, STUCK_LIMIT
// Options : CAR_DETECTOR_STUCK_DETECT_EN - when defined, builds the
//           stuck-sensor detector (sticky sensor_fault, forces car_present).
//           When undefined, sensor_fault is tied low.
// Revision: 1.0 - initial release
// ============================================================================
module car_detector
  import car_detector_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 2,
  parameter int WAIT_W      = 8,
  parameter int STUCK_LIMIT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  car_detector_if.slave  det
);

  if (SYNC_STAGES < 2 || DEBOUNCE < 1 || WAIT_W < 1 || STUCK_LIMIT < 1) begin : g_param_check
    $error("car_detector: illegal parameter value");
  end

  logic              deb;
  logic              served;
  logic              fault_force;
  det_state_e        state_q, state_d;
  logic              car_present_q, car_present_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  car_detector_sync_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE    (DEBOUNCE)
  ) u_sync_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .sensor_i (det.sensor_raw),
    .deb_o    (deb)
  );

  assign served = is_served(det.light_pros);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      car_present_q <= 1'b0;
      wait_q        <= '0;
    end else begin
      state_q       <= state_d;
      car_present_q <= car_present_d;
      wait_q        <= wait_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_d        = '0;
    car_present_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A car arriving while the light is already green is served at once.
        if (deb) begin
          state_d = served ? ST_SERVED : ST_WAITING;
        end
      end
      ST_WAITING: begin
        if (served) begin
          state_d = ST_SERVED;
        end
      end
      ST_SERVED: begin
        if (!served) begin
          state_d = deb ? ST_WAITING : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Wait time restarts from zero on every entry into WAITING.
    if (state_q == ST_WAITING && state_d == ST_WAITING) begin
      wait_d = (&wait_q) ? wait_q : wait_q + 1'b1;
    end

    // Output is registered from the next state; in SERVED it follows the
    // sensor so back-to-back cars keep the request up.
    unique case (state_d)
      ST_WAITING: car_present_d = 1'b1;
      ST_SERVED:  car_present_d = deb;
      default:    car_present_d = 1'b0;
    endcase

    if (fault_force) begin
      car_present_d = 1'b1;
    end
  end

`ifdef CAR_DETECTOR_STUCK_DETECT_EN
  localparam int STK_W = $clog2(STUCK_LIMIT + 1);

  logic [STK_W-1:0] stk_q, stk_d;
  logic             fault_q, fault_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stk_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      stk_q   <= stk_d;
      fault_q <= fault_d;
    end
  end

  // Counts consecutive debounced-high cycles; the fault is sticky until reset.
  always_comb begin
    stk_d   = '0;
    fault_d = fault_q;
    if (deb) begin
      stk_d = (stk_q == STK_W'(STUCK_LIMIT)) ? stk_q : stk_q + 1'b1;
      if (stk_d == STK_W'(STUCK_LIMIT)) begin
        fault_d = 1'b1;
      end
    end
  end

  // Using the next-state fault keeps car_present and sensor_fault asserting
  // on the same edge.
  assign fault_force      = fault_d;
  assign det.sensor_fault = fault_q;
`else
  assign fault_force      = 1'b0;
  assign det.sensor_fault = 1'b0;
`endif

  assign det.car_present = car_present_q;
  assign det.wait_count  = wait_q;

endmodule
`default_nettype wire

// File: tb/tb_car_detector.sv
`default_nettype none
// ============================================================================
// Module  : tb_car_detector
// Purpose : Self-checking bench for car_detector. A cycle model of the
//           detector pushes expected outputs into a queue as each stimulus
//           cycle is driven; they are popped and compared once the DUT edge
//           has happened. Directed checks cover latency, latching, service,
//           saturation and asynchronous reset.
// Options : CAR_DETECTOR_STUCK_DETECT_EN - runs the stuck-sensor scenario.
// Revision: 1.0 - initial release
// ============================================================================
module tb_car_detector;
  import car_detector_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int DEBOUNCE    = 2;
  localparam int WAIT_W      = 8;
  localparam int STUCK_LIMIT = 8;

  typedef struct packed {
    logic              cp;
    logic [WAIT_W-1:0] wc;
    logic              flt;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  exp_t sb_q[$];

  // Model state
  logic [SYNC_STAGES-1:0] m_sync;
  logic                   m_deb;
  int                     m_run;
  int                     m_st;   // 0 idle, 1 waiting, 2 served
  int                     m_wc;
  int                     m_stk;
  logic                   m_flt;

  car_detector_if #(.WAIT_W(WAIT_W)) det_if ();

  car_detector #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE    (DEBOUNCE),
    .WAIT_W      (WAIT_W),
    .STUCK_LIMIT (STUCK_LIMIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .det   (det_if)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sync = '0;
    m_deb  = 1'b0;
    m_run  = 0;
    m_st   = 0;
    m_wc   = 0;
    m_stk  = 0;
    m_flt  = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs presented to it.
  task automatic model_step(input logic raw, input logic [2:0] lp);
    logic deb_now;
    logic sync_now;
    logic served;
    logic cp;
    int   nst;
    exp_t e;
    deb_now  = m_deb;
    sync_now = m_sync[SYNC_STAGES-1];
    served   = (lp == 3'b100);

    if (sync_now != m_deb) begin
      m_run++;
      if (m_run == DEBOUNCE) begin
        m_deb = ~m_deb;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_sync = {m_sync[SYNC_STAGES-2:0], raw};

    nst = m_st;
    case (m_st)
      0: if (deb_now) nst = served ? 2 : 1;
      1: if (served) nst = 2;
      default: if (!served) nst = deb_now ? 1 : 0;
    endcase
    m_wc = (m_st == 1 && nst == 1) ? ((m_wc == 255) ? 255 : m_wc + 1) : 0;

`ifdef CAR_DETECTOR_STUCK_DETECT_EN
    if (deb_now) begin
      if (m_stk < STUCK_LIMIT) m_stk++;
      if (m_stk == STUCK_LIMIT) m_flt = 1'b1;
    end else begin
      m_stk = 0;
    end
`endif

    cp   = (nst == 1) || (nst == 2 && deb_now) || m_flt;
    m_st = nst;
    e.cp  = cp;
    e.wc  = WAIT_W'(m_wc);
    e.flt = m_flt;
    sb_q.push_back(e);
  endtask

  // Called just after a falling edge: drive, predict, clock, compare.
  task automatic tick(input logic raw, input logic [2:0] lp);
    exp_t e;
    det_if.sensor_raw = raw;
    det_if.light_pros = lp;
    model_step(raw, lp);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    check_value("car_present", 32'(det_if.car_present), 32'(e.cp));
    check_value("wait_count", 32'(det_if.wait_count), 32'(e.wc));
    check_value("sensor_fault", 32'(det_if.sensor_fault), 32'(e.flt));
  endtask

  task automatic check_reset_state(input string tag);
    exp_t e;
    sb_q.push_back('0);
    e = sb_q.pop_front();
    check_value({tag, "_cp"}, 32'(det_if.car_present), 32'(e.cp));
    check_value({tag, "_wc"}, 32'(det_if.wait_count), 32'(e.wc));
    check_value({tag, "_flt"}, 32'(det_if.sensor_fault), 32'(e.flt));
  endtask

  task automatic sync_reset_cycle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    det_if.sensor_raw = 1'b0;
    det_if.light_pros = LIGHT_RED;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

`ifdef CAR_DETECTOR_STUCK_DETECT_EN
    // Stuck sensor under green: fault from the STUCK_LIMIT-th debounced-high cycle.
    for (int i = 1; i <= 20; i++) begin
      tick(1'b1, LIGHT_GRN);
      if (i == 11) check_value("stuck_before_limit", 32'(det_if.sensor_fault), 32'd0);
      if (i == 12) check_value("stuck_at_limit", 32'(det_if.sensor_fault), 32'd1);
    end
    check_value("stuck_forced_cp", 32'(det_if.car_present), 32'd1);
    for (int i = 0; i < 10; i++) tick(1'b0, LIGHT_GRN);
    check_value("stuck_sticky", 32'(det_if.sensor_fault), 32'd1);
    check_value("stuck_sticky_cp", 32'(det_if.car_present), 32'd1);
    sync_reset_cycle();
    tick(1'b0, LIGHT_RED);
`else
    // Latency: raw rise before edge 1 -> car_present after edge 5.
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, LIGHT_RED);
      if (i == 4) check_value("lat_edge4_cp", 32'(det_if.car_present), 32'd0);
      if (i == 5) check_value("lat_edge5_cp", 32'(det_if.car_present), 32'd1);
      if (i == 5) check_value("lat_edge5_wc", 32'(det_if.wait_count), 32'd0);
      if (i == 6) check_value("lat_edge6_wc", 32'(det_if.wait_count), 32'd1);
      if (i == 7) check_value("lat_edge7_wc", 32'(det_if.wait_count), 32'd2);
    end

    // Car leaves before service: request stays latched.
    for (int i = 0; i < 6; i++) tick(1'b0, LIGHT_RED);
    check_value("latched_cp", 32'(det_if.car_present), 32'd1);
    tick(1'b0, LIGHT_GRN);
    check_value("served_cp", 32'(det_if.car_present), 32'd0);
    check_value("served_wc", 32'(det_if.wait_count), 32'd0);
    for (int i = 0; i < 3; i++) tick(1'b0, LIGHT_RED);
    check_value("idle_cp", 32'(det_if.car_present), 32'd0);

    // One-cycle glitch is filtered.
    tick(1'b1, LIGHT_RED);
    for (int i = 0; i < 8; i++) tick(1'b0, LIGHT_RED);
    check_value("glitch_cp", 32'(det_if.car_present), 32'd0);
    check_value("glitch_wc", 32'(det_if.wait_count), 32'd0);

    // Request up, then an illegal multi-hot code is not service.
    for (int i = 0; i < 6; i++) tick(1'b1, LIGHT_RED);
    for (int i = 0; i < 3; i++) tick(1'b1, 3'b110);
    check_value("illegal_cp", 32'(det_if.car_present), 32'd1);
    check_value("illegal_wc", 32'(det_if.wait_count), 32'd4);

    // Stream of cars through GRN/YLW/RED: request never drops.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 9; i++) begin
        tick(1'b1, (i < 3) ? LIGHT_GRN : (i < 6) ? LIGHT_YLW : LIGHT_RED);
        check_value("stream_cp", 32'(det_if.car_present), 32'd1);
      end
    end

    // Saturation of wait_count.
    for (int i = 0; i < 260; i++) tick(1'b1, LIGHT_RED);
    check_value("sat_wc", 32'(det_if.wait_count), 32'd255);

    // Asynchronous reset between edges, mid-WAITING.
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b0, LIGHT_RED);
    check_value("post_rst_cp", 32'(det_if.car_present), 32'd0);

    // Arrival while already green goes straight to SERVED.
    for (int i = 0; i < 6; i++) tick(1'b1, LIGHT_GRN);
    check_value("green_arrival_cp", 32'(det_if.car_present), 32'd1);
    check_value("green_arrival_wc", 32'(det_if.wait_count), 32'd0);
    sync_reset_cycle();
    tick(1'b0, LIGHT_RED);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/car_detector.md
Name: car_detector

Overview:
- Front end for the Stoplight controller's car_present input.
- Converts a raw, asynchronous, bouncy Prospect loop-sensor signal into a clean, latched car_present request.
- Holds the request until the controller serves it (Prospect light green), then tracks the sensor for a continuing stream of cars.
- Sits between the pad-level sensor and Stoplight.car_present; observes Stoplight.light_pros as the service acknowledge.

Parameters:
- SYNC_STAGES, 2: flops in the input synchronizer (legal range 2 or more).
- DEBOUNCE, 2: consecutive cycles the synchronized sensor must differ from the debounced value before that value flips (legal range 1 or more).
- WAIT_W, 8: width of the wait_count counter.
- STUCK_LIMIT, 64: cycles of continuous debounced-high that flag a stuck sensor (used only with the optional feature).

Ports:
- clk  in  1  system clock; one tick is one controller time step.
- rst  in  1  asynchronous, active-low reset.
- sensor_raw  in  1  raw loop-sensor level, asynchronous to clk.
- light_pros  in  3  Prospect light code from Stoplight: GRN=100, YLW=010, RED=001.
- car_present  out  1  registered request to Stoplight.
- wait_count  out  WAIT_W  cycles the current request has waited unserved; saturating.
- sensor_fault  out  1  stuck-sensor flag; sticky.

Behaviour:
- Reset (rst=0, asynchronous):
  - synchronizer, debounced value and debounce counter all clear to 0.
  - FSM goes to IDLE.
  - car_present=0, wait_count=0, sensor_fault=0.
  - Reset asserted mid-operation aborts everything immediately; no request is remembered.
- Synchronizer: SYNC_STAGES flop chain, reset to 0; its output is sync_s.
- Debounce:
  - Counter increments each cycle while sync_s differs from deb.
  - Counter clears whenever sync_s equals deb.
  - When the counter reaches DEBOUNCE, deb flips and the counter clears on the same edge.
  - Glitches shorter than DEBOUNCE cycles never reach deb.
- Served condition: served = (light_pros == 3'b100). Any other code, including illegal non-one-hot codes, is not served.
- FSM states (car_present is registered from the next state):
  - IDLE: car_present=0. deb rising goes to WAITING.
  - WAITING: car_present=1, wait_count increments each cycle and saturates at all-ones. served goes to SERVED and clears wait_count. The request stays latched even if deb falls before service.
  - SERVED: car_present=deb, so a stream of cars keeps the request high. When served drops: deb=1 goes to WAITING, deb=0 goes to IDLE.
  - Simultaneous deb rise and served in IDLE: enter SERVED directly; car_present=1 only while deb=1.
- Latency: a raw rising edge stable before edge 1 produces car_present=1 after edge SYNC_STAGES+DEBOUNCE+1 (5 with defaults). Falling latency in SERVED is the same.
- wait_count holds 0 in IDLE and SERVED.

Optional Feature:
- Macro: CAR_DETECTOR_STUCK_DETECT_EN.
- Defined:
  - A counter runs while deb=1 continuously and clears when deb=0.
  - When it reaches STUCK_LIMIT, sensor_fault sets and stays set until rst.
  - While sensor_fault=1, car_present is forced to 1 (fail-safe: the controller keeps cycling both roads).
- Undefined: sensor_fault is tied to 0 and no counter logic is built.

Decomposition:
- Shared header stoplight_defs.v, used by Stoplight, this block and the benches:
  - light codes GRN, YLW, RED.
  - car_detector FSM state encodings IDLE, WAITING, SERVED.
- One sub-module: sync_debounce, containing the synchronizer chain, the debounce counter and the deb output, parameterised by SYNC_STAGES and DEBOUNCE.

Test Plan:
- Reset, then sensor_raw=1 held with light_pros=RED: car_present=1 exactly 5 edges after the rise; wait_count=0 on that edge, then counts 1, 2, 3...
- 1-cycle pulse on sensor_raw with DEBOUNCE=2: car_present stays 0 and the FSM stays in IDLE.
- Request latched, then sensor_raw drops before service: car_present stays 1. Set light_pros=GRN: car_present goes to 0 on that edge, wait_count=0. Set light_pros=RED: FSM returns to IDLE.
- Stream of cars (sensor_raw=1 throughout) and light_pros cycling GRN, YLW, RED: car_present stays 1 continuously and re-enters WAITING when GRN drops.
- Pulse rst low mid-WAITING, asynchronously between edges: car_present=0 and wait_count=0 immediately, without waiting for a clock edge.
- With CAR_DETECTOR_STUCK_DETECT_EN and STUCK_LIMIT=8, sensor_raw=1 for 20 cycles under GRN: sensor_fault=1 from the 8th debounced-high cycle onward, car_present forced to 1, and the fault persists after sensor_raw=0 until rst.
